// File: rtl/rggen_wide_register.sv
// rggen_wide_register: a register spanning several bus words. Lower words are
// staged and committed atomically by the top-word write, and reads are made
// coherent by snapshotting the whole value on a word-0 read.
module rggen_wide_register #(
  parameter int                            ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0]      START_ADDRESS = '0,
  parameter int                            DATA_WIDTH    = 32,
  parameter int                            WORDS         = 2,
  parameter logic [WORDS*DATA_WIDTH-1:0]   INITIAL_VALUE = '0,
  parameter logic [WORDS*DATA_WIDTH-1:0]   WRITABLE_MASK = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          access_valid,
  input  logic [ADDRESS_WIDTH-1:0]      access_address,
  input  logic                          access_write,
  input  logic [DATA_WIDTH-1:0]         access_write_data,
  input  logic [DATA_WIDTH-1:0]         access_strobe,
  output logic                          access_ready,
  output logic [DATA_WIDTH-1:0]         access_read_data,
  input  logic                          hw_write_valid,
  input  logic [WORDS*DATA_WIDTH-1:0]   hw_write_data,
  output logic [WORDS*DATA_WIDTH-1:0]   value_out,
  output logic                          value_update
);

  localparam int VW      = WORDS * DATA_WIDTH;
  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int LSB     = $clog2(BYTES);
  localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TOP_LSB = (WORDS - 1) * DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(BYTES - 1);
  localparam logic [ADDRESS_WIDTH:0]   SPAN       = (ADDRESS_WIDTH + 1)'(WORDS * BYTES);
  localparam logic [IDX_W-1:0]         TOP        = IDX_W'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RESPOND = 1'b1
  } state_t;

  state_t                   state_r;
  logic [VW-1:0]            staging_r;
  logic [VW-1:0]            snapshot_r;

  logic [ADDRESS_WIDTH-1:0] offset_s;
  logic [IDX_W-1:0]         index_s;
  logic                     hit_s;
  logic                     commit_s;
  logic                     stage_s;
  logic                     read_s;
  logic [DATA_WIDTH-1:0]    mask_s;
  logic [DATA_WIDTH-1:0]    merged_s;
  logic [DATA_WIDTH-1:0]    read_data_s;
  logic [VW-1:0]            value_next_s;
  logic [VW-1:0]            staging_next_s;

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] data,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (old_word & ~mask) | (data & mask);
  endfunction

  // Address decode, write merge and next-state of value, staging and read data.
  always_comb begin
    offset_s = access_address - START_ADDRESS;
    index_s  = IDX_W'(offset_s >> LSB);
    hit_s    = access_valid && (state_r == IDLE) &&
               ({1'b0, offset_s} < SPAN) && ((offset_s & ALIGN_MASK) == '0);
    commit_s = hit_s && access_write && (index_s == TOP);
    stage_s  = hit_s && access_write && (index_s != TOP);
    read_s   = hit_s && !access_write;
    mask_s   = access_strobe & WRITABLE_MASK[index_s*DATA_WIDTH +: DATA_WIDTH];

    // The top word merges against the committed value, lower words against staging.
    if (commit_s) begin
      merged_s = merge_word(value_out[index_s*DATA_WIDTH +: DATA_WIDTH], access_write_data, mask_s);
    end else begin
      merged_s = merge_word(staging_r[index_s*DATA_WIDTH +: DATA_WIDTH], access_write_data, mask_s);
    end

    staging_next_s = staging_r;
    for (int w = 0; w < WORDS; w++) begin
      staging_next_s[w*DATA_WIDTH +: DATA_WIDTH] =
        (stage_s && (index_s == IDX_W'(w))) ? merged_s :
        hw_write_valid ? hw_write_data[w*DATA_WIDTH +: DATA_WIDTH] :
                         staging_r[w*DATA_WIDTH +: DATA_WIDTH];
    end

    // A software commit takes priority over a simultaneous hardware load.
    if (commit_s) begin
      value_next_s = staging_r;
      value_next_s[TOP_LSB +: DATA_WIDTH] = merged_s;
      staging_next_s = value_next_s;
    end else if (hw_write_valid) begin
      value_next_s = hw_write_data;
    end else begin
      value_next_s = value_out;
    end

    if (!read_s) begin
      read_data_s = '0;
    end else if (index_s == '0) begin
      read_data_s = value_out[DATA_WIDTH-1:0];
    end else begin
      read_data_s = snapshot_r[index_s*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Handshake FSM plus all registered state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      access_ready     <= 1'b0;
      access_read_data <= '0;
      value_update     <= 1'b0;
      value_out        <= INITIAL_VALUE;
      staging_r        <= INITIAL_VALUE;
      snapshot_r       <= INITIAL_VALUE;
    end else begin
      case (state_r)
        IDLE:    state_r <= hit_s ? RESPOND : IDLE;
        RESPOND: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
      access_ready     <= hit_s;
      access_read_data <= read_data_s;
      value_update     <= commit_s;
      value_out        <= value_next_s;
      staging_r        <= staging_next_s;
      if (read_s && (index_s == '0)) begin
        snapshot_r <= value_out;
      end else begin
        snapshot_r <= snapshot_r;
      end
    end
  end

endmodule

// File: tb/tb_rggen_wide_register.sv
// Bench for rggen_wide_register: directed vector table, hand sequences for
// mask/reset corners, and random traffic against a word-level reference model.
module tb_rggen_wide_register;

  localparam logic [63:0] INIT  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] MASKB = 64'hFFFF_0000_FFFF_FFFF;
  localparam logic [31:0] FULL  = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        access_valid;
  logic [15:0] access_address;
  logic        access_write;
  logic [31:0] access_write_data;
  logic [31:0] access_strobe;
  logic        hw_write_valid;
  logic [63:0] hw_write_data;

  logic        ready_a, ready_b, update_a, update_b;
  logic [31:0] rdata_a, rdata_b;
  logic [63:0] value_a, value_b;

  rggen_wide_register #(
    .ADDRESS_WIDTH(16), .START_ADDRESS(16'h0010), .DATA_WIDTH(32), .WORDS(2),
    .INITIAL_VALUE(INIT), .WRITABLE_MASK(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut_a (
    .clk(clk), .rst(rst), .access_valid(access_valid), .access_address(access_address),
    .access_write(access_write), .access_write_data(access_write_data),
    .access_strobe(access_strobe), .access_ready(ready_a), .access_read_data(rdata_a),
    .hw_write_valid(hw_write_valid), .hw_write_data(hw_write_data),
    .value_out(value_a), .value_update(update_a)
  );

  rggen_wide_register #(
    .ADDRESS_WIDTH(16), .START_ADDRESS(16'h0010), .DATA_WIDTH(32), .WORDS(2),
    .INITIAL_VALUE(INIT), .WRITABLE_MASK(MASKB)
  ) dut_b (
    .clk(clk), .rst(rst), .access_valid(access_valid), .access_address(access_address),
    .access_write(access_write), .access_write_data(access_write_data),
    .access_strobe(access_strobe), .access_ready(ready_b), .access_read_data(rdata_b),
    .hw_write_valid(hw_write_valid), .hw_write_data(hw_write_data),
    .value_out(value_b), .value_update(update_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations: cycle 1 is the response cycle, cycle 2 the one after.
  logic        o1_ready [2];
  logic [31:0] o1_rdata [2];
  logic        o1_upd   [2];
  logic [63:0] o1_val   [2];
  logic        o2_ready [2];
  logic        o2_upd   [2];
  logic [63:0] o2_val   [2];

  // Reference model: per instance, words of value, staging and snapshot.
  logic [31:0] mval  [2][2];
  logic [31:0] mstg  [2][2];
  logic [31:0] msnap [2][2];
  logic [63:0] wm    [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 2; w++) begin
        mval[i][w]  = INIT[w*32 +: 32];
        mstg[i][w]  = INIT[w*32 +: 32];
        msnap[i][w] = INIT[w*32 +: 32];
      end
    end
  endtask

  function automatic logic [63:0] mvalue(input int i);
    return {mval[i][1], mval[i][0]};
  endfunction

  // One clock edge of the register's behaviour, computed from the access rules.
  task automatic model_step(input int i, input logic v, input logic [15:0] a, input logic w,
                            input logic [31:0] d, input logic [31:0] s, input logic hv,
                            input logic [63:0] hd, output logic hit, output logic [31:0] rd,
                            output logic upd);
    logic [15:0] off16;
    int          off;
    int          idx;
    logic [31:0] m;
    logic [31:0] nv [2];
    logic [31:0] ns [2];
    off16 = a - 16'h0010;
    off   = int'(off16);
    hit   = v && (off < 8) && (off % 4 == 0);
    idx   = off / 4;
    rd    = 32'h0;
    upd   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nv[k] = hv ? hd[k*32 +: 32] : mval[i][k];
      ns[k] = hv ? hd[k*32 +: 32] : mstg[i][k];
    end
    if (hit && w) begin
      m = s & wm[i][idx*32 +: 32];
      if (idx == 1) begin
        nv[1] = (mval[i][1] & ~m) | (d & m);
        nv[0] = mstg[i][0];
        ns[0] = nv[0];
        ns[1] = nv[1];
        upd   = 1'b1;
      end else begin
        ns[0] = (mstg[i][0] & ~m) | (d & m);
      end
    end
    if (hit && !w) begin
      if (idx == 0) begin
        rd = mval[i][0];
        msnap[i][0] = mval[i][0];
        msnap[i][1] = mval[i][1];
      end else begin
        rd = msnap[i][idx];
      end
    end
    for (int k = 0; k < 2; k++) begin
      mval[i][k] = nv[k];
      mstg[i][k] = ns[k];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    access_valid = 1'b0;
    hw_write_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One request sampled at the next edge, then one cycle with the request dropped.
  task automatic do_access(input logic v, input logic [15:0] a, input logic w,
                           input logic [31:0] d, input logic [31:0] s,
                           input logic hv, input logic [63:0] hd,
                           input logic hv2, input logic [63:0] hd2);
    access_valid = v; access_address = a; access_write = w;
    access_write_data = d; access_strobe = s;
    hw_write_valid = hv; hw_write_data = hd;
    @(posedge clk);
    #1;
    o1_ready[0] = ready_a; o1_rdata[0] = rdata_a; o1_upd[0] = update_a; o1_val[0] = value_a;
    o1_ready[1] = ready_b; o1_rdata[1] = rdata_b; o1_upd[1] = update_b; o1_val[1] = value_b;
    access_valid = 1'b0;
    hw_write_valid = hv2; hw_write_data = hd2;
    @(posedge clk);
    #1;
    o2_ready[0] = ready_a; o2_upd[0] = update_a; o2_val[0] = value_a;
    o2_ready[1] = ready_b; o2_upd[1] = update_b; o2_val[1] = value_b;
    hw_write_valid = 1'b0;
  endtask

  typedef struct {
    logic        rst_before;
    logic        valid;
    logic [15:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [31:0] strb;
    logic        hw;
    logic [63:0] hwd;
    logic        e_ready;
    logic [31:0] e_rdata;
    logic        e_upd;
    logic [63:0] e_val;
  } vec_t;

  vec_t vt [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        hit;
    logic [31:0] rd;
    logic        upd;
    logic        v, w, hv, hv2;
    logic [15:0] a;
    logic [31:0] d, s;
    logic [63:0] hd, hd2;

    wm[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wm[1] = MASKB;
    rst = 1'b0; access_valid = 1'b0; access_address = 16'h0; access_write = 1'b0;
    access_write_data = 32'h0; access_strobe = 32'h0;
    hw_write_valid = 1'b0; hw_write_data = 64'h0;

    vt[0]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 32'hAAAA_AAAA, FULL, 1'b0, 64'h0, 1'b1, 32'h0, 1'b0, INIT};
    vt[1]  = '{1'b0, 1'b1, 16'h0014, 1'b1, 32'h5555_5555, FULL, 1'b0, 64'h0, 1'b1, 32'h0, 1'b1, 64'h5555_5555_AAAA_AAAA};
    vt[2]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b1, 32'h3333_4444, 1'b0, INIT};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 32'h0, 32'h0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 32'h0, 1'b0, 64'hDEAD_BEEF_0000_0001};
    vt[4]  = '{1'b0, 1'b1, 16'h0014, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b1, 32'h1111_2222, 1'b0, 64'hDEAD_BEEF_0000_0001};
    vt[5]  = '{1'b1, 1'b1, 16'h0014, 1'b1, 32'h0, FULL, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'h0, 1'b1, 64'h0000_0000_3333_4444};
    vt[6]  = '{1'b0, 1'b1, 16'h0012, 1'b1, 32'h1234_5678, FULL, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0000_0000_3333_4444};
    vt[7]  = '{1'b0, 1'b1, 16'h0018, 1'b1, 32'h8765_4321, FULL, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h0000_0000_3333_4444};
    vt[8]  = '{1'b0, 1'b1, 16'h0014, 1'b1, 32'h9999_9999, FULL, 1'b0, 64'h0, 1'b1, 32'h0, 1'b1, 64'h9999_9999_3333_4444};
    vt[9]  = '{1'b0, 1'b1, 16'h0010, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b1, 32'h3333_4444, 1'b0, 64'h9999_9999_3333_4444};
    vt[10] = '{1'b0, 1'b1, 16'h0014, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b1, 32'h9999_9999, 1'b0, 64'h9999_9999_3333_4444};
    vt[11] = '{1'b0, 1'b1, 16'h000C, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 64'h9999_9999_3333_4444};

    // Reset state
    do_reset();
    chk("reset_value_a", value_a, INIT);
    chk("reset_value_b", value_b, INIT);
    chk("reset_ready", ready_a, 1'b0);
    chk("reset_update", update_a, 1'b0);
    chk("reset_rdata", rdata_a, 32'h0);

    // Directed vector table on the full-mask instance
    for (int n = 0; n < 12; n++) begin
      if (vt[n].rst_before) do_reset();
      do_access(vt[n].valid, vt[n].addr, vt[n].wr, vt[n].data, vt[n].strb,
                vt[n].hw, vt[n].hwd, 1'b0, 64'h0);
      chk($sformatf("vec%0d_ready", n), o1_ready[0], vt[n].e_ready);
      chk($sformatf("vec%0d_rdata", n), o1_rdata[0], vt[n].e_rdata);
      chk($sformatf("vec%0d_update", n), o1_upd[0], vt[n].e_upd);
      chk($sformatf("vec%0d_value", n), o1_val[0], vt[n].e_val);
      chk($sformatf("vec%0d_ready_after", n), o2_ready[0], 1'b0);
      chk($sformatf("vec%0d_update_after", n), o2_upd[0], 1'b0);
    end

    // Strobe and writable mask
    do_reset();
    do_access(1'b1, 16'h0014, 1'b1, FULL, 32'h00FF_FFFF, 1'b0, 64'h0, 1'b0, 64'h0);
    chk("mask_value_b", o1_val[1], 64'h11FF_2222_3333_4444);
    chk("mask_value_a", o1_val[0], 64'h11FF_FFFF_3333_4444);
    do_access(1'b1, 16'h0010, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    do_access(1'b1, 16'h0014, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    chk("mask_read_b", o1_rdata[1], 32'h11FF_2222);

    // Reset on the edge that samples a commit: no response, no commit
    do_reset();
    access_valid = 1'b1; access_address = 16'h0014; access_write = 1'b1;
    access_write_data = 32'h0; access_strobe = FULL; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", ready_a, 1'b0);
    chk("rst_req_update", update_a, 1'b0);
    chk("rst_req_value", value_a, INIT);
    access_valid = 1'b0; rst = 1'b0;

    // Reset in the RESPOND cycle: response dropped, value back to reset
    @(posedge clk);
    #1;
    access_valid = 1'b1; access_address = 16'h0014; access_write = 1'b1;
    access_write_data = 32'h0; access_strobe = FULL;
    @(posedge clk);
    #1;
    chk("rsp_ready", ready_a, 1'b1);
    chk("rsp_value", value_a, 64'h0000_0000_3333_4444);
    access_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_rst_ready", ready_a, 1'b0);
    chk("rsp_rst_update", update_a, 1'b0);
    chk("rsp_rst_value", value_a, INIT);
    rst = 1'b0;

    // Random traffic against the reference model
    do_reset();
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = 16'h0010;
        2, 3:    a = 16'h0014;
        4:       a = 16'(16'h000C + 16'($urandom_range(0, 16)));
        default: a = 16'($urandom);
      endcase
      v   = ($urandom_range(0, 7) != 0);
      w   = $urandom_range(0, 1) == 1;
      d   = $urandom;
      s   = ($urandom_range(0, 1) == 1) ? FULL : $urandom;
      hv  = ($urandom_range(0, 3) == 0);
      hd  = {$urandom, $urandom};
      hv2 = ($urandom_range(0, 4) == 0);
      hd2 = {$urandom, $urandom};
      do_access(v, a, w, d, s, hv, hd, hv2, hd2);
      for (int i = 0; i < 2; i++) begin
        model_step(i, v, a, w, d, s, hv, hd, hit, rd, upd);
        chk($sformatf("rnd%0d_ready_%0d", t, i), o1_ready[i], hit);
        chk($sformatf("rnd%0d_rdata_%0d", t, i), o1_rdata[i], rd);
        chk($sformatf("rnd%0d_update_%0d", t, i), o1_upd[i], upd);
        chk($sformatf("rnd%0d_value_%0d", t, i), o1_val[i], mvalue(i));
        model_step(i, 1'b0, 16'h0, 1'b0, 32'h0, 32'h0, hv2, hd2, hit, rd, upd);
        chk($sformatf("rnd%0d_ready2_%0d", t, i), o2_ready[i], 1'b0);
        chk($sformatf("rnd%0d_update2_%0d", t, i), o2_upd[i], 1'b0);
        chk($sformatf("rnd%0d_value2_%0d", t, i), o2_val[i], mvalue(i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
